// File: rtl/mem_test_mem_bridge.sv
// Memory-side access bridge: takes single-word read/write requests over a
// valid/ready handshake and drives a synchronous single-port SRAM with a fixed
// read latency. One access in flight at a time; Moore FSM plus latency counter.
module mem_test_mem_bridge #(
    parameter int DATUM_WIDTH  = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n_async,
    input  logic                   i_clear,
    input  logic                   i_req_valid,
    input  logic                   i_req_write,
    input  logic [ADDR_WIDTH-1:0]  i_req_addr,
    input  logic [DATUM_WIDTH-1:0] i_req_wdata,
    output logic                   o_req_ready,
    output logic                   o_write_ready,
    output logic                   o_read_valid,
    output logic [DATUM_WIDTH-1:0] o_rdata,
    output logic                   o_busy,
    output logic                   o_mem_cs,
    output logic                   o_mem_we,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    output logic [DATUM_WIDTH-1:0] o_mem_wdata,
    input  logic [DATUM_WIDTH-1:0] i_mem_rdata
);

    localparam int               CNT_W    = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_READ      = 3'd2,
        S_READ_WAIT = 3'd3,
        S_READ_DONE = 3'd4
    } state_e;

    // The request direction is captured by the state itself (WRITE vs READ),
    // so no separate write-flag register is kept.
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;
    logic [DATUM_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATUM_WIDTH-1:0] rdata_q, rdata_d;

    // State, counter and datapath registers; reset returns everything to zero/IDLE
    always_ff @(posedge i_clk or negedge i_rst_n_async) begin
        if (!i_rst_n_async) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: handshake capture, latency countdown, clear override
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    state_d = i_req_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_READ: begin
                cnt_d   = CNT_LOAD;
                state_d = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    rdata_d = i_mem_rdata;
                    state_d = S_READ_DONE;
                end
            end
            S_READ_DONE: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        // Clear wins over everything, including a handshake offered in IDLE
        if (i_clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            addr_d  = '0;
            wdata_d = '0;
            rdata_d = '0;
        end
    end

    // Output decode from current state and registers only
    always_comb begin
        o_req_ready   = 1'b0;
        o_write_ready = 1'b0;
        o_read_valid  = 1'b0;
        o_mem_cs      = 1'b0;
        o_mem_we      = 1'b0;
        unique case (state_q)
            S_IDLE:      o_req_ready = 1'b1;
            S_WRITE: begin
                o_mem_cs      = 1'b1;
                o_mem_we      = 1'b1;
                o_write_ready = 1'b1;
            end
            S_READ:      o_mem_cs = 1'b1;
            S_READ_WAIT: o_mem_cs = 1'b0;
            S_READ_DONE: o_read_valid = 1'b1;
            default:     o_req_ready = 1'b0;
        endcase
    end

    assign o_busy      = (state_q != S_IDLE);
    assign o_rdata     = rdata_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_test_mem_bridge.sv
// Testbench for mem_test_mem_bridge: four bridge instances (read latencies
// 2, 4, 1, 15), each with its own SRAM model. Expected data comes from a
// simple array of last-written values; expected timing from latency arithmetic.
module tb_mem_test_mem_bridge;

    localparam int N = 4;
    localparam int RLS [N] = '{2, 4, 1, 15};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       clear       [N];
    logic       req_valid   [N];
    logic       req_write   [N];
    logic [7:0] req_addr    [N];
    logic [7:0] req_wdata   [N];
    logic       req_ready   [N];
    logic       write_ready [N];
    logic       read_valid  [N];
    logic [7:0] rdata       [N];
    logic       busy        [N];
    logic       mem_cs      [N];
    logic       mem_we      [N];
    logic [7:0] mem_addr    [N];
    logic [7:0] mem_wdata   [N];
    logic [7:0] mem_rdata   [N];

    logic [7:0] ref_mem [N][256];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < N; gi++) begin : g_inst
        localparam int RL = RLS[gi];
        logic [7:0] sram [256];
        logic [7:0] pipe [RL];

        mem_test_mem_bridge #(
            .DATUM_WIDTH (8),
            .ADDR_WIDTH  (8),
            .READ_LATENCY(RL)
        ) u_dut (
            .i_clk        (clk),
            .i_rst_n_async(rst_n),
            .i_clear      (clear[gi]),
            .i_req_valid  (req_valid[gi]),
            .i_req_write  (req_write[gi]),
            .i_req_addr   (req_addr[gi]),
            .i_req_wdata  (req_wdata[gi]),
            .o_req_ready  (req_ready[gi]),
            .o_write_ready(write_ready[gi]),
            .o_read_valid (read_valid[gi]),
            .o_rdata      (rdata[gi]),
            .o_busy       (busy[gi]),
            .o_mem_cs     (mem_cs[gi]),
            .o_mem_we     (mem_we[gi]),
            .o_mem_addr   (mem_addr[gi]),
            .o_mem_wdata  (mem_wdata[gi]),
            .i_mem_rdata  (mem_rdata[gi])
        );

        // SRAM: data is valid exactly RL cycles after a read strobe, junk otherwise
        always @(posedge clk) begin
            if (mem_cs[gi] && mem_we[gi]) sram[mem_addr[gi]] <= mem_wdata[gi];
            pipe[0] <= (mem_cs[gi] && !mem_we[gi]) ? sram[mem_addr[gi]] : 8'($urandom);
            for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[gi] = pipe[RL-1];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int k, input logic [7:0] a, input logic [7:0] d);
        chk($sformatf("wr%0d_%02h.ready", k, a), {63'd0, req_ready[k]}, 64'd1);
        req_valid[k] = 1'b1; req_write[k] = 1'b1; req_addr[k] = a; req_wdata[k] = d;
        step();
        req_valid[k] = 1'b0; req_addr[k] = 8'($urandom); req_wdata[k] = 8'($urandom);
        chk($sformatf("wr%0d_%02h.strobe", k, a),
            {write_ready[k], mem_cs[k], mem_we[k], busy[k], req_ready[k], read_valid[k], mem_addr[k], mem_wdata[k]},
            {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, a, d});
        ref_mem[k][a] = d;
        step();
        chk($sformatf("wr%0d_%02h.after", k, a),
            {req_ready[k], write_ready[k], busy[k], mem_cs[k]}, {1'b1, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic do_read(input int k, input logic [7:0] a);
        int n;
        logic [7:0] exp_d;
        exp_d = ref_mem[k][a];
        chk($sformatf("rd%0d_%02h.ready", k, a), {63'd0, req_ready[k]}, 64'd1);
        req_valid[k] = 1'b1; req_write[k] = 1'b0; req_addr[k] = a;
        step();
        // A competing write held while busy must be ignored
        req_valid[k] = 1'b1; req_write[k] = 1'b1;
        req_addr[k] = 8'($urandom); req_wdata[k] = 8'($urandom);
        chk($sformatf("rd%0d_%02h.strobe", k, a),
            {mem_cs[k], mem_we[k], busy[k], req_ready[k], read_valid[k], write_ready[k], mem_addr[k]},
            {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a});
        n = 1;
        while (read_valid[k] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        req_valid[k] = 1'b0;
        chk($sformatf("rd%0d_%02h.latency", k, a), 64'(n), 64'(RLS[k] + 2));
        chk($sformatf("rd%0d_%02h.data", k, a), {56'd0, rdata[k]}, {56'd0, exp_d});
        step();
        chk($sformatf("rd%0d_%02h.after", k, a),
            {req_ready[k], busy[k], read_valid[k], rdata[k]}, {1'b1, 1'b0, 1'b0, exp_d});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0;
        logic seen;
        logic [7:0] a;

        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            clear[k] = 1'b0; req_valid[k] = 1'b0; req_write[k] = 1'b0;
            req_addr[k] = 8'h00; req_wdata[k] = 8'h00;
            for (int j = 0; j < 256; j++) ref_mem[k][j] = 8'h00;
        end
        repeat (3) step();
        for (int k = 0; k < N; k++)
            chk($sformatf("reset%0d", k),
                {req_ready[k], busy[k], mem_cs[k], mem_we[k], write_ready[k], read_valid[k], rdata[k], mem_addr[k], mem_wdata[k]},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
        rst_n = 1'b1;
        step();

        // Single write and read
        do_write(0, 8'h3C, 8'hA5);
        do_write(0, 8'h3C, 8'h5A);
        do_read(0, 8'h3C);

        // Full sweep with throughput check
        t0 = cyc;
        for (int i = 0; i < 256; i++) do_write(0, 8'(i), ~8'(i));
        chk("sweep.write_cycles", 64'(cyc - t0), 64'd512);
        t0 = cyc;
        for (int i = 0; i < 256; i++) do_read(0, 8'(i));
        chk("sweep.read_cycles", 64'(cyc - t0), 64'(256 * (RLS[0] + 3)));

        // Random mix on the fully initialised instance
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom_range(255));
            if ($urandom_range(1) == 1) do_write(0, a, 8'($urandom));
            else                        do_read(0, a);
        end

        // Latency extremes
        for (int k = 2; k < N; k++) begin
            for (int i = 0; i < 6; i++) begin
                a = 8'($urandom_range(255));
                do_write(k, a, 8'($urandom));
                do_read(k, a);
            end
        end

        // Clear during READ_WAIT (latency 4)
        do_write(1, 8'h11, 8'h96);
        do_read(1, 8'h11);
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 8'h11;
        step();
        req_valid[1] = 1'b0;
        step();
        chk("clr_wait.busy", {63'd0, busy[1]}, 64'd1);
        clear[1] = 1'b1;
        step();
        clear[1] = 1'b0;
        chk("clr_wait.after", {req_ready[1], busy[1], read_valid[1], rdata[1], mem_addr[1]},
            {1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
        seen = 1'b0;
        repeat (8) begin
            step();
            seen = seen | read_valid[1];
        end
        chk("clr_wait.no_pulse", {63'd0, seen}, 64'd0);

        // Request offered together with clear in IDLE is not accepted
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 8'h22; req_wdata[1] = 8'h33;
        clear[1] = 1'b1;
        step();
        clear[1] = 1'b0; req_valid[1] = 1'b0;
        chk("clr_idle.not_taken", {req_ready[1], busy[1], mem_cs[1], write_ready[1]},
            {1'b1, 1'b0, 1'b0, 1'b0});

        // Clear coinciding with a WRITE cycle still commits the write
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 8'h44; req_wdata[1] = 8'hC3;
        step();
        req_valid[1] = 1'b0;
        clear[1] = 1'b1;
        chk("clr_write.strobe", {write_ready[1], mem_cs[1], mem_we[1], mem_addr[1], mem_wdata[1]},
            {1'b1, 1'b1, 1'b1, 8'h44, 8'hC3});
        ref_mem[1][8'h44] = 8'hC3;
        step();
        clear[1] = 1'b0;
        chk("clr_write.after", {req_ready[1], mem_addr[1], mem_wdata[1]}, {1'b1, 8'h00, 8'h00});
        do_read(1, 8'h44);

        // Async reset in the middle of a read (latency 2)
        do_read(0, 8'h01);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 8'h02;
        step();
        req_valid[0] = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid.outputs",
            {req_ready[0], busy[0], mem_cs[0], mem_we[0], write_ready[0], read_valid[0], rdata[0], mem_addr[0], mem_wdata[0]},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
        step();
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            step();
            seen = seen | read_valid[0];
        end
        chk("rst_mid.no_pulse", {63'd0, seen}, 64'd0);
        chk("rst_mid.idle", {req_ready[0], busy[0], rdata[0]}, {1'b1, 1'b0, 8'h00});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
